// File: rtl/pc_gen_if.sv
// Fetch-stage bundle: pipeline control, EX redirect, BTB update and the
// fetch/ID program-counter outputs of pc_gen.
interface pc_gen_if;
  logic        stall_IF;
  logic        stall_ID;
  logic        flush_ID;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_btb_update;
  logic [31:0] i_btb_pc;
  logic [31:0] i_btb_target;
  logic [31:0] o_pc;
  logic [31:0] o_pc_ID;
  logic [31:0] o_pc4_ID;
  logic        o_valid_ID;
  logic        o_pred_taken_ID;

  modport master (
    input  stall_IF, stall_ID, flush_ID,
    input  i_redirect, i_redirect_pc,
    input  i_btb_update, i_btb_pc, i_btb_target,
    output o_pc, o_pc_ID, o_pc4_ID, o_valid_ID, o_pred_taken_ID
  );

  modport slave (
    output stall_IF, stall_ID, flush_ID,
    output i_redirect, i_redirect_pc,
    output i_btb_update, i_btb_pc, i_btb_target,
    input  o_pc, o_pc_ID, o_pc4_ID, o_valid_ID, o_pred_taken_ID
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generation: fetch PC, ID-stage PC register, EX redirects.
// Optional direct-mapped BTB built when PC_GEN_BTB_EN is defined.
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 8
) (
  input logic      i_clk,
  input logic      i_rstn,
  pc_gen_if.master bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  logic [31:0] pc_p0;
  logic [31:0] pc_nxt;
  logic [31:0] pc_p1;
  logic        vld_p1;
  logic        pred_p1;
  logic        btb_hit;
  logic [31:0] btb_tgt;

`ifdef PC_GEN_BTB_EN
  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [31:0]            btb_dat [BTB_ENTRIES];
  logic [IDX_W-1:0]       rd_idx;
  logic [IDX_W-1:0]       wr_idx;
  logic                   unused_btb;

  assign rd_idx     = pc_p0[IDX_W+1:2];
  assign wr_idx     = bus.i_btb_pc[IDX_W+1:2];
  assign btb_hit    = btb_vld[rd_idx] && (btb_tag[rd_idx] == pc_p0[31:IDX_W+2]);
  assign btb_tgt    = btb_dat[rd_idx];
  assign unused_btb = ^bus.i_btb_pc[1:0];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      btb_vld <= '0;
    else if (bus.i_btb_update)
      btb_vld[wr_idx] <= 1'b1;
  end

  // Tag/target storage carries no reset; the valid bit alone qualifies it.
  always_ff @(posedge i_clk) begin
    if (bus.i_btb_update) begin
      btb_tag[wr_idx] <= bus.i_btb_pc[31:IDX_W+2];
      btb_dat[wr_idx] <= word_align(bus.i_btb_target);
    end
  end
`else
  logic unused_btb;

  assign btb_hit    = 1'b0;
  assign btb_tgt    = '0;
  assign unused_btb = ^{bus.i_btb_update, bus.i_btb_pc, bus.i_btb_target};
`endif

  // Next fetch PC: a redirect must win over stall_IF so a resolved branch is never dropped.
  always_comb begin
    pc_nxt = pc_inc(pc_p0);
    if (bus.i_redirect)
      pc_nxt = word_align(bus.i_redirect_pc);
    else if (bus.stall_IF)
      pc_nxt = pc_p0;
    else if (btb_hit)
      pc_nxt = btb_tgt;
  end

  // Stage p0: fetch address register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      pc_p0 <= RESET_PC;
    else
      pc_p0 <= pc_nxt;
  end

  // Stage p1: ID slot, lock-step with the instruction memory output register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_p1   <= '0;
      vld_p1  <= 1'b0;
      pred_p1 <= 1'b0;
    end else if (bus.stall_ID) begin
      pc_p1   <= pc_p1;
      vld_p1  <= vld_p1;
      pred_p1 <= pred_p1;
    end else if (bus.flush_ID) begin
      pc_p1   <= '0;
      vld_p1  <= 1'b0;
      pred_p1 <= 1'b0;
    end else begin
      pc_p1   <= pc_p0;
      vld_p1  <= 1'b1;
      pred_p1 <= btb_hit;
    end
  end

  assign bus.o_pc            = pc_p0;
  assign bus.o_pc_ID         = pc_p1;
  assign bus.o_pc4_ID        = pc_inc(pc_p1);
  assign bus.o_valid_ID      = vld_p1;
  assign bus.o_pred_taken_ID = pred_p1;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver pushes hand-computed expectations per edge,
// monitor pops and compares on the following falling edge.
module tb_pc_gen;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;

  pc_gen_if bus ();

  pc_gen #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(8)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus.master)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id;
    logic        v;
    logic        p;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk("o_pc",            bus.o_pc,                     e.pc);
    chk("o_pc_ID",         bus.o_pc_ID,                  e.id);
    chk("o_pc4_ID",        bus.o_pc4_ID,                 e.id + 32'd4);
    chk("o_valid_ID",      {31'd0, bus.o_valid_ID},      {31'd0, e.v});
    chk("o_pred_taken_ID", {31'd0, bus.o_pred_taken_ID}, {31'd0, e.p});
  endtask

  // Monitor: registered outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (q.size() > 0) chk_outputs(q.pop_front());
    end
  end

  task automatic idle_inputs();
    bus.stall_IF      = 1'b0;
    bus.stall_ID      = 1'b0;
    bus.flush_ID      = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_btb_update  = 1'b0;
    bus.i_btb_pc      = '0;
    bus.i_btb_target  = '0;
  endtask

  task automatic step(input logic sif, input logic sid, input logic fl,
                      input logic rd, input logic [31:0] rpc,
                      input logic upd, input logic [31:0] bpc, input logic [31:0] btgt,
                      input logic [31:0] e_pc, input logic [31:0] e_id,
                      input logic e_v, input logic e_p);
    exp_t e;
    bus.stall_IF      = sif;
    bus.stall_ID      = sid;
    bus.flush_ID      = fl;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
    bus.i_btb_update  = upd;
    bus.i_btb_pc      = bpc;
    bus.i_btb_target  = btgt;
    @(posedge i_clk);
    e.pc = e_pc; e.id = e_id; e.v = e_v; e.p = e_p;
    q.push_back(e);
    @(negedge i_clk);
    #1;
    idle_inputs();
  endtask

  task automatic plain(input logic [31:0] e_pc, input logic [31:0] e_id,
                       input logic e_v, input logic e_p);
    step(0, 0, 0, 0, '0, 0, '0, '0, e_pc, e_id, e_v, e_p);
  endtask

  task automatic check_reset_state();
    exp_t e;
    e.pc = 32'h0; e.id = 32'h0; e.v = 1'b0; e.p = 1'b0;
    chk_outputs(e);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    check_reset_state();
    @(posedge i_clk);
    #1;
    check_reset_state();
    @(negedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    #12;
    check_reset_state();
    @(negedge i_clk);
    #1;
    i_rstn = 1'b1;

    // Sequential fetch from reset
    plain(32'h4,  32'h0, 1, 0);
    plain(32'h8,  32'h4, 1, 0);
    plain(32'hC,  32'h8, 1, 0);
    plain(32'h10, 32'hC, 1, 0);

    // Three-cycle stall of IF and ID at 0x10
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 0, '0, 0, '0, '0, 32'h10, 32'hC, 1, 0);
    plain(32'h14, 32'h10, 1, 0);
    plain(32'h18, 32'h14, 1, 0);

    // Redirect beats stall_IF, low bits dropped, wrong-path slot flushed
    step(1, 0, 1, 1, 32'h203, 0, '0, '0, 32'h200, 32'h0, 0, 0);
    plain(32'h204, 32'h200, 1, 0);

    // stall_ID and flush_ID together: slot held
    step(0, 1, 1, 0, '0, 0, '0, '0, 32'h208, 32'h200, 1, 0);
    plain(32'h20C, 32'h208, 1, 0);

    // Wrap of the fetch PC and of o_pc4_ID
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, '0, '0, 32'hFFFF_FFFC, 32'h20C, 1, 0);
    plain(32'h0, 32'hFFFF_FFFC, 1, 0);
    plain(32'h4, 32'h0, 1, 0);

    // Asynchronous reset mid-operation
    do_reset();
    plain(32'h4, 32'h0, 1, 0);
    plain(32'h8, 32'h4, 1, 0);

`ifdef PC_GEN_BTB_EN
    do_reset();
    // Record branch 0x40 -> 0x103 (stored as 0x100) while fetching 0x0
    step(0, 0, 0, 0, '0, 1, 32'h40, 32'h103, 32'h4, 32'h0, 1, 0);
    for (int a = 8; a <= 32'h40; a += 4)
      plain(a, a - 4, 1, 0);
    plain(32'h100, 32'h40, 1, 1);
    plain(32'h104, 32'h100, 1, 0);

    // Update coincident with first lookup: no hit that cycle
    step(0, 0, 1, 1, 32'h144, 0, '0, '0, 32'h144, 32'h0, 0, 0);
    step(0, 0, 0, 0, '0, 1, 32'h144, 32'h300, 32'h148, 32'h144, 1, 0);
    step(0, 0, 1, 1, 32'h144, 0, '0, '0, 32'h144, 32'h0, 0, 0);
    plain(32'h300, 32'h144, 1, 1);
    plain(32'h304, 32'h300, 1, 0);
`endif

    for (int w = 0; w < 20 && q.size() > 0; w++)
      @(negedge i_clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage of the 5-stage pipeline. It sits directly upstream of the instruction memory. It drives the fetch address each cycle and registers a copy of the fetched PC into the ID stage, in lock-step with the memory's registered instruction output. It handles sequential fetch, stalls, and EX-stage redirects. An optional small branch target buffer (BTB) predicts taken branches at fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 8, number of direct-mapped BTB entries (power of two, 2–64).

Ports:
- i_clk  in  1  pipeline clock.
- i_rstn  in  1  asynchronous active-low reset.
- stall_IF  in  1  hold the fetch PC.
- stall_ID  in  1  hold the ID-stage PC register (same signal as the instruction memory's stall).
- flush_ID  in  1  squash the ID-stage slot (same signal as the instruction memory's flush).
- i_redirect  in  1  EX-stage redirect (mispredict or jump) valid.
- i_redirect_pc  in  32  redirect target.
- i_btb_update  in  1  write one BTB entry.
- i_btb_pc  in  32  PC of the branch being recorded.
- i_btb_target  in  32  target of the branch being recorded.
- o_pc  out  32  fetch address to instruction memory; reset RESET_PC.
- o_pc_ID  out  32  PC of the instruction currently in ID; reset 0.
- o_pc4_ID  out  32  o_pc_ID + 4; reset 4.
- o_valid_ID  out  1  ID slot holds a real instruction; reset 0.
- o_pred_taken_ID  out  1  ID instruction was predicted taken by the BTB; reset 0.

## Operation
- Next-PC priority: i_redirect, then stall_IF (hold), then BTB hit (BTB_EN only), then o_pc + 4.
- A redirect wins over stall_IF, so a resolved branch is never lost.
- Redirect target bits [1:0] are forced to 00. All other PC sources are word-aligned by construction.
- o_pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- ID register priority, matching instruction memory exactly:
  - reset: pc_ID = 0, valid = 0, pred = 0.
  - else stall_ID: hold all ID outputs.
  - else flush_ID: pc_ID = 0, valid = 0, pred = 0.
  - else: pc_ID = o_pc, valid = 1, pred = BTB hit on o_pc.
- o_pc4_ID is combinational from o_pc_ID, 32-bit wrap.
- stall_ID with flush_ID asserted together: the stall wins and the slot is held.

## Timing
- Fetch latency is one cycle. The instruction for o_pc appears at the memory output on the same edge that loads o_pc into o_pc_ID.
- After reset release, the first edge presents RESET_PC in ID with o_valid_ID = 1.
- A redirect asserted in cycle N gives o_pc = target after edge N. The redirect source flushes the wrong-path ID slot by asserting flush_ID in cycle N.
- Reset asserted mid-operation immediately forces every output to its reset value, independent of the clock.

## Configuration
- PC_GEN_BTB_EN defined:
  - The BTB is built: BTB_ENTRIES entries of {valid, tag = pc[31:2+log2(BTB_ENTRIES)], target}, indexed by pc[log2(BTB_ENTRIES)+1:2].
  - Lookup on o_pc is combinational. A hit requires valid and a tag match.
  - i_btb_update writes the entry at the clock edge, replacing any prior entry. The stored target has bits [1:0] forced to 00.
  - A lookup in the same cycle as an update to the same index sees the old contents.
  - Reset clears all valid bits.
- PC_GEN_BTB_EN undefined:
  - No BTB storage is built.
  - i_btb_* inputs are ignored.
  - o_pred_taken_ID is tied to 0.
  - Next PC is redirect, hold, or o_pc + 4.

## Test plan
- Reset with RESET_PC = 0, then release with no stalls → o_pc = 0, 4, 8, 12 on successive edges; o_pc_ID lags by one edge; o_valid_ID = 1 from the first edge.
- stall_IF and stall_ID high for 3 cycles at o_pc = 0x10 → o_pc stays 0x10 and o_pc_ID stays 0x0C; sequencing resumes at 0x14 after release.
- i_redirect = 1 with i_redirect_pc = 0x203 and stall_IF = 1 → o_pc = 0x200 next edge; flush_ID in the same cycle → o_valid_ID = 0 and o_pc_ID = 0.
- stall_ID = 1 and flush_ID = 1 together → ID outputs unchanged.
- o_pc = 0xFFFF_FFFC with no stall → next o_pc = 0; o_pc4_ID = 0 when o_pc_ID = 0xFFFF_FFFC.
- (PC_GEN_BTB_EN) Update pc = 0x40, target = 0x100; fetch reaches 0x40 → next o_pc = 0x100 and o_pred_taken_ID = 1 with o_pc_ID = 0x40. An update coincident with the first lookup of 0x40 → no hit that cycle, next o_pc = 0x44.
